// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial sequence-detector family.
//   DEF_PAT_LEN / DEF_CNT_W : default pattern length and hit-counter width
//   OVL_OFF / OVL_ON        : encoding of the cfg_overlap control bit
package seq_det_pkg;

  localparam int unsigned DEF_PAT_LEN = 4;
  localparam int unsigned DEF_CNT_W   = 8;

  localparam logic OVL_OFF = 1'b0;
  localparam logic OVL_ON  = 1'b1;

endpackage : seq_det_pkg

// File: rtl/pattern_detector_if.sv
// Bus bundle for pattern_detector: configuration, serial input and status.
//   master : bit source / controller (drives cfg_*, cnt_clr, din_valid, din)
//   slave  : the detector (drives detected, hit_count, cnt_sat)
interface pattern_detector_if #(
  parameter int unsigned PAT_LEN = 4,
  parameter int unsigned CNT_W   = 8
);

  logic               cfg_load;
  logic [PAT_LEN-1:0] cfg_pattern;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               din_valid;
  logic               din;
  logic               detected;
  logic [CNT_W-1:0]   hit_count;
  logic               cnt_sat;

  modport master (
    output cfg_load, cfg_pattern, cfg_overlap, cnt_clr, din_valid, din,
    input  detected, hit_count, cnt_sat
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_overlap, cnt_clr, din_valid, din,
    output detected, hit_count, cnt_sat
  );

endinterface : pattern_detector_if

// File: rtl/sat_counter.sv
// Saturating event counter with sticky saturation flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one event (ignored once count is all-ones)
//   clr        : synchronous clear; applied before a same-cycle inc
//   count      : current count
//   sat        : sticky, set when count becomes all-ones
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         sat
);

  logic [W-1:0] count_q, count_d, base;
  logic         sat_q, sat_d;

  // Clear first, then count, so a clear coincident with an event leaves 1.
  always_comb begin
    base    = clr ? '0 : count_q;
    count_d = base;
    if (inc && (base != '1)) begin
      count_d = base + W'(1);
    end
    sat_d = (clr ? 1'b0 : sat_q) | (count_d == '1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign sat   = sat_q;

endmodule : sat_counter

// File: rtl/pattern_detector.sv
// Parametrised serial bit-pattern detector with runtime-loaded pattern,
// selectable overlapping / non-overlapping matching and a saturating hit counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pattern_detector_if slave
//                cfg_load/cfg_pattern/cfg_overlap : pattern load and match mode
//                cnt_clr                          : clear hit counter
//                din_valid/din                    : qualified serial input
//                detected                         : one-cycle pulse per match
//                hit_count/cnt_sat                : saturating match count
module pattern_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_LEN = DEF_PAT_LEN,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input logic               clk,
  input logic               rst_n,
  pattern_detector_if.slave bus
);

  localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d, fill_inc;
  logic               det_q, det_d;
  logic               match;
  logic [CNT_W-1:0]   hit_count;
  logic               cnt_sat;

  always_comb begin
    pat_d    = pat_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    fill_inc = fill_q;
    det_d    = 1'b0;
    match    = 1'b0;
    if (bus.cfg_load) begin
      // Load wins over a coincident sample; that bit is dropped.
      pat_d  = bus.cfg_pattern;
      hist_d = '0;
      fill_d = '0;
    end else if (bus.din_valid) begin
      hist_d   = (hist_q << 1) | PAT_LEN'(bus.din);
      fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
      // fill guards against stale/reset history matching before PAT_LEN fresh bits.
      match    = (hist_d == pat_q) && (fill_inc == FILL_FULL);
      fill_d   = (match && (bus.cfg_overlap != OVL_ON)) ? '0 : fill_inc;
      det_d    = match;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q  <= '0;
      hist_q <= '0;
      fill_q <= '0;
      det_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      det_q  <= det_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (match),
    .clr   (bus.cnt_clr),
    .count (hit_count),
    .sat   (cnt_sat)
  );

  assign bus.detected  = det_q;
  assign bus.hit_count = hit_count;
  assign bus.cnt_sat   = cnt_sat;

endmodule : pattern_detector
